adder_bist_checker: RTL

ADDER_BIST_CHECKER -- requirements
Module: adder_bist_checker

---
 rtl/adder_bist_pkg.sv | 36 +++
 rtl/lfsr_16.sv | 24 ++
 rtl/adder_bist_checker.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/adder_bist_pkg.sv
// Shared types, constants and helpers for the adder BIST checker and its LFSRs.
package adder_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
   localparam logic [15:0] LFSR_POLY     = 16'hB400;
   localparam logic [15:0] ZERO_SEED_SUB = 16'h0001;
   localparam int          NUM_CORNERS   = 4;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        c_in;
   } vector_t;

   localparam vector_t CORNER_TABLE [NUM_CORNERS] = '{
      '{a: 16'd0,     b: 16'd0,     c_in: 1'b0},
      '{a: 16'd65535, b: 16'd65535, c_in: 1'b1},
      '{a: 16'd43690, b: 16'd21845, c_in: 1'b1},
      '{a: 16'd65505, b: 16'd31,    c_in: 1'b0}
   };

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_POLY : 16'h0000);
   endfunction

   function automatic logic [15:0] seed_fix(input logic [15:0] seed);
      return (seed == 16'h0000) ? ZERO_SEED_SUB : seed;
   endfunction

endpackage

// File: rtl/lfsr_16.sv
// 16-bit Galois LFSR; value always holds the next random operand to be applied.
module lfsr_16
   import adder_bist_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic [15:0] seed,
   output logic [15:0] value
);

   // Load and step together means the seed itself is consumed this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= ZERO_SEED_SUB;
      end else if (load) begin
         value <= step ? lfsr_next(seed_fix(seed)) : seed_fix(seed);
      end else if (step) begin
         value <= lfsr_next(value);
      end
   end

endmodule

// File: rtl/adder_bist_checker.sv
// BIST driver/checker for a 16-bit combinational adder.
// Define ADDER_BIST_CORNER_EN to prepend four directed corner vectors to each run.
module adder_bist_checker
   import adder_bist_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] num_patterns,
   input  logic [15:0] seed_a,
   input  logic [15:0] seed_b,
   output logic [15:0] a,
   output logic [15:0] b,
   output logic        c_in,
   input  logic [15:0] s,
   input  logic        c_out,
   input  logic        BP,
   input  logic        BG,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [16:0] fail_idx,
   output logic [15:0] fail_s
);

`ifdef ADDER_BIST_CORNER_EN
   localparam bit CORNERS_ON = 1'b1;
`else
   localparam bit CORNERS_ON = 1'b0;
`endif

   localparam logic [16:0] CORNER_COUNT = CORNERS_ON ? 17'(NUM_CORNERS) : 17'd0;

   state_t      state;
   logic [16:0] idx;
   logic [16:0] last_idx;
   logic [16:0] nxt_idx;
   logic [16:0] total;
   logic        accept_start;
   logic        next_is_corner;
   logic        lfsr_load;
   logic        lfsr_step;
   logic [15:0] lfsr_a_val;
   logic [15:0] lfsr_b_val;
   logic [16:0] gold_sum;
   logic        gold_bp;
   logic        gold_bg;
   logic        mismatch;
   logic [15:0] err_next;

   assign total          = {1'b0, num_patterns} + CORNER_COUNT;
   assign nxt_idx        = idx + 17'd1;
   assign accept_start   = start && (state == ST_IDLE || state == ST_DONE);
   assign next_is_corner = CORNERS_ON && (nxt_idx < 17'(NUM_CORNERS));
   assign lfsr_load      = accept_start;
   assign lfsr_step      = (accept_start && !CORNERS_ON) ||
                           (state == ST_RUN && idx != last_idx && !next_is_corner);

   // Golden model of the adder; the block carry is an unsigned overflow of a+b.
   assign gold_sum = {1'b0, a} + {1'b0, b} + {16'd0, c_in};
   assign gold_bp  = &(a ^ b);
   assign gold_bg  = (16'(a + b) < a);
   assign mismatch = (s != gold_sum[15:0]) || (c_out != gold_sum[16]) ||
                     (BP != gold_bp) || (BG != gold_bg);
   assign err_next = (mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;

   lfsr_16 u_lfsr_a (
      .clk   (clk),
      .rst   (rst),
      .load  (lfsr_load),
      .step  (lfsr_step),
      .seed  (seed_a),
      .value (lfsr_a_val)
   );

   lfsr_16 u_lfsr_b (
      .clk   (clk),
      .rst   (rst),
      .load  (lfsr_load),
      .step  (lfsr_step),
      .seed  (seed_b),
      .value (lfsr_b_val)
   );

   // Pattern k is applied at edge k and checked at edge k+1 against the golden sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         a         <= 16'd0;
         b         <= 16'd0;
         c_in      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= 16'd0;
         fail_idx  <= 17'd0;
         fail_s    <= 16'd0;
         idx       <= 17'd0;
         last_idx  <= 17'd0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  err_count <= 16'd0;
                  fail_idx  <= 17'd0;
                  fail_s    <= 16'd0;
                  idx       <= 17'd0;
                  last_idx  <= total - 17'd1;
                  if (CORNERS_ON) begin
                     a    <= CORNER_TABLE[0].a;
                     b    <= CORNER_TABLE[0].b;
                     c_in <= CORNER_TABLE[0].c_in;
                  end else begin
                     a    <= seed_fix(seed_a);
                     b    <= seed_fix(seed_b);
                     c_in <= 1'b0;
                  end
                  if (total == 17'd0) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                     pass  <= 1'b0;
                  end
               end
            end
            ST_RUN: begin
               err_count <= err_next;
               if (mismatch && err_count == 16'd0) begin
                  fail_idx <= idx;
                  fail_s   <= s;
               end
               if (idx == last_idx) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == 16'd0);
               end else begin
                  idx <= nxt_idx;
                  if (next_is_corner) begin
                     a    <= CORNER_TABLE[nxt_idx[1:0]].a;
                     b    <= CORNER_TABLE[nxt_idx[1:0]].b;
                     c_in <= CORNER_TABLE[nxt_idx[1:0]].c_in;
                  end else begin
                     a    <= lfsr_a_val;
                     b    <= lfsr_b_val;
                     c_in <= nxt_idx[0];
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
